rf_scoreboard: RTL and testbench

- Register-file write scoreboard for the pipelined MIPS core.
- Sits beside the 32x32 register file (two async read ports, one write port).
- Tracks every issued but not yet retired register write.
- Generates the decode-stage stall when a source register or a destination slot is still pending.
- Snoops the register-file write port (A3/RFWr) to retire pending writes.

---
 rtl/rf_scoreboard_if.sv | 32 +++
 rtl/rf_scoreboard.sv | 131 +++++++++++++
 tb/tb_rf_scoreboard.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_scoreboard_if.sv
// Decode/writeback-side bundle of the register-file write scoreboard.
// The master drives decode and writeback snoop signals; the slave is the scoreboard.
interface rf_scoreboard_if #(
   parameter int INF_W = 3
);
   logic             id_valid;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic [4:0]       id_rd;
   logic             id_wr;
   logic             id_stall;
   logic             wb_we;
   logic [4:0]       wb_a3;
   logic             flush;
   logic [31:0]      busy_mask;
   logic [INF_W-1:0] inflight;
   logic             err;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr,
      output wb_we, wb_a3, flush,
      input  id_stall, busy_mask, inflight, err
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr,
      input  wb_we, wb_a3, flush,
      output id_stall, busy_mask, inflight, err
   );
endinterface

// File: rtl/rf_scoreboard.sv
// Register-file write scoreboard: counts outstanding writes per register,
// stalls decode on RAW hazards / counter or in-flight saturation, retires on RF writes.
module rf_scoreboard #(
   parameter int CNT_W        = 2,
   parameter int MAX_INFLIGHT = 4,
   parameter int WB_BYPASS    = 0,
   parameter int INF_W        = 3
) (
   input logic             clk,
   input logic             rst,
   rf_scoreboard_if.slave  sb
);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

   logic [CNT_W-1:0] cnt_reg [32];
   logic [31:0]      busy_next;
   logic [31:0]      busy_reg;
   logic [INF_W-1:0] inflight_reg;
   logic [INF_W-1:0] inflight_next;
   logic             err_reg;

   logic [CNT_W-1:0] cnt_a3;
   logic [CNT_W-1:0] cnt_rs;
   logic [CNT_W-1:0] cnt_rt;
   logic [CNT_W-1:0] cnt_rd;
   logic             retire_req;
   logic             retire_ok;
   logic             rs_pend;
   logic             rt_pend;
   logic             stall;
   logic             issue;
   logic             issue_eff;

   assign cnt_a3 = cnt_reg[sb.wb_a3];
   assign cnt_rs = cnt_reg[sb.id_rs];
   assign cnt_rt = cnt_reg[sb.id_rt];
   assign cnt_rd = cnt_reg[sb.id_rd];

   // A retire to an idle register is an error and must not touch inflight.
   assign retire_req = sb.wb_we && (sb.wb_a3 != 5'd0) && !sb.flush;
   assign retire_ok  = retire_req && (cnt_a3 != '0);

   // With a forwarding network, a source whose last write retires now is ready.
   assign rs_pend = (cnt_rs != '0) &&
                    !((WB_BYPASS != 0) && (cnt_rs == CNT_W'(1)) && retire_ok && (sb.wb_a3 == sb.id_rs));
   assign rt_pend = (cnt_rt != '0) &&
                    !((WB_BYPASS != 0) && (cnt_rt == CNT_W'(1)) && retire_ok && (sb.wb_a3 == sb.id_rt));

   always_comb begin
      stall = 1'b0;
      if (sb.id_valid) begin
         if (sb.id_use_rs && (sb.id_rs != 5'd0) && rs_pend)
            stall = 1'b1;
         if (sb.id_use_rt && (sb.id_rt != 5'd0) && rt_pend)
            stall = 1'b1;
         if (sb.id_wr && (sb.id_rd != 5'd0) && (cnt_rd == CNT_MAX))
            stall = 1'b1;
         if (sb.id_wr && (sb.id_rd != 5'd0) && (inflight_reg == INF_MAX) && !retire_ok)
            stall = 1'b1;
      end
   end

   assign issue     = sb.id_valid && !stall && sb.id_wr && (sb.id_rd != 5'd0);
   assign issue_eff = issue && !sb.flush;

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_cnt
         if (gi == 0) begin : g_zero
            assign cnt_reg[gi]   = '0;
            assign busy_next[gi] = 1'b0;
         end else begin : g_track
            logic             inc;
            logic             dec;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            assign inc = issue_eff && (sb.id_rd == 5'(gi));
            assign dec = retire_ok && (sb.wb_a3 == 5'(gi));

            always_comb begin
               cnt_d = cnt_q;
               if (sb.flush)
                  cnt_d = '0;
               else if (inc && !dec)
                  cnt_d = cnt_q + CNT_W'(1);
               else if (dec && !inc)
                  cnt_d = cnt_q - CNT_W'(1);
            end

            always_ff @(posedge clk or posedge rst) begin
               if (rst)
                  cnt_q <= '0;
               else
                  cnt_q <= cnt_d;
            end

            assign cnt_reg[gi]   = cnt_q;
            assign busy_next[gi] = (cnt_d != '0);
         end
      end
   endgenerate

   always_comb begin
      inflight_next = inflight_reg;
      if (sb.flush)
         inflight_next = '0;
      else if (issue_eff && !retire_ok)
         inflight_next = inflight_reg + INF_W'(1);
      else if (retire_ok && !issue_eff)
         inflight_next = inflight_reg - INF_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_reg     <= '0;
         inflight_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         busy_reg     <= busy_next;
         inflight_reg <= inflight_next;
         err_reg      <= err_reg || (retire_req && (cnt_a3 == '0));
      end
   end

   assign sb.id_stall  = stall;
   assign sb.busy_mask = busy_reg;
   assign sb.inflight  = inflight_reg;
   assign sb.err       = err_reg;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: one instance without and one with WB bypass,
// driven through linear steps with hand-computed expectations.
module tb_rf_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rf_scoreboard_if #(.INF_W(3)) sb ();
   rf_scoreboard_if #(.INF_W(3)) sb1 ();

   rf_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(4), .WB_BYPASS(0), .INF_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb.slave)
   );

   rf_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(4), .WB_BYPASS(1), .INF_W(3)) dut_bp (
      .clk (clk),
      .rst (rst),
      .sb  (sb1.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-14s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic idle();
      sb.id_valid = 0; sb.id_rs = 0; sb.id_rt = 0; sb.id_use_rs = 0; sb.id_use_rt = 0;
      sb.id_rd = 0; sb.id_wr = 0; sb.wb_we = 0; sb.wb_a3 = 0; sb.flush = 0;
   endtask

   task automatic idle1();
      sb1.id_valid = 0; sb1.id_rs = 0; sb1.id_rt = 0; sb1.id_use_rs = 0; sb1.id_use_rt = 0;
      sb1.id_rd = 0; sb1.id_wr = 0; sb1.wb_we = 0; sb1.wb_a3 = 0; sb1.flush = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rd);
      sb.id_valid = 1; sb.id_wr = 1; sb.id_rd = rd;
   endtask

   initial begin
      idle();
      idle1();
      tick();
      tick();
      chk("rst_busy", sb.busy_mask, 32'h0);
      chk("rst_infl", 32'(sb.inflight), 32'd0);
      chk("rst_err", 32'(sb.err), 32'd0);
      rst = 1'b0;
      tick();

      // Basic RAW hazard on r5
      issue(5'd5);
      #1 chk("iss5_stall", 32'(sb.id_stall), 32'd0);
      tick();
      idle();
      chk("iss5_busy", sb.busy_mask, 32'h0000_0020);
      chk("iss5_infl", 32'(sb.inflight), 32'd1);
      sb.id_valid = 1; sb.id_use_rs = 1; sb.id_rs = 5'd5;
      #1 chk("raw5_stall", 32'(sb.id_stall), 32'd1);
      sb.id_use_rs = 0;
      #1 chk("raw5_nouse", 32'(sb.id_stall), 32'd0);
      sb.id_use_rs = 1; sb.wb_we = 1; sb.wb_a3 = 5'd5;
      #1 chk("nobyp_stall", 32'(sb.id_stall), 32'd1);
      tick();
      sb.wb_we = 0; sb.wb_a3 = 0;
      chk("ret5_busy", sb.busy_mask, 32'h0);
      chk("ret5_infl", 32'(sb.inflight), 32'd0);
      #1 chk("raw5_clear", 32'(sb.id_stall), 32'd0);
      idle();

      // Counter saturation on r8
      for (int i = 0; i < 3; i++) begin
         issue(5'd8);
         #1 chk("iss8_stall", 32'(sb.id_stall), 32'd0);
         tick();
      end
      chk("cnt8_infl", 32'(sb.inflight), 32'd3);
      chk("cnt8_busy", sb.busy_mask, 32'h0000_0100);
      #1 chk("sat8_stall", 32'(sb.id_stall), 32'd1);
      sb.wb_we = 1; sb.wb_a3 = 5'd8;
      #1 chk("sat8_retst", 32'(sb.id_stall), 32'd1);
      tick();
      sb.wb_we = 0; sb.wb_a3 = 0;
      chk("ret8_infl", 32'(sb.inflight), 32'd2);
      #1 chk("sat8_drop", 32'(sb.id_stall), 32'd0);
      tick();
      chk("acc8_infl", 32'(sb.inflight), 32'd3);

      // Flush with inflight=3; same-cycle issue and retire ignored
      issue(5'd10);
      sb.wb_we = 1; sb.wb_a3 = 5'd8; sb.flush = 1;
      tick();
      idle();
      chk("fl_busy", sb.busy_mask, 32'h0);
      chk("fl_infl", 32'(sb.inflight), 32'd0);
      chk("fl_err", 32'(sb.err), 32'd0);

      // In-flight limit with same-cycle retire
      for (int r = 1; r <= 4; r++) begin
         issue(5'(r));
         tick();
      end
      idle();
      chk("lim_infl", 32'(sb.inflight), 32'd4);
      chk("lim_busy", sb.busy_mask, 32'h0000_001E);
      issue(5'd9);
      #1 chk("lim_stall", 32'(sb.id_stall), 32'd1);
      sb.wb_we = 1; sb.wb_a3 = 5'd2;
      #1 chk("lim_retst", 32'(sb.id_stall), 32'd0);
      tick();
      idle();
      chk("lim_infl2", 32'(sb.inflight), 32'd4);
      chk("lim_busy2", sb.busy_mask, 32'h0000_021A);
      sb.id_valid = 1; sb.id_use_rt = 1; sb.id_rt = 5'd9;
      #1 chk("raw9_rt", 32'(sb.id_stall), 32'd1);
      idle();
      sb.flush = 1;
      tick();
      idle();
      chk("fl2_infl", 32'(sb.inflight), 32'd0);

      // Register 0 is never tracked
      sb.id_valid = 1; sb.id_use_rs = 1; sb.id_use_rt = 1; sb.id_rs = 0; sb.id_rt = 0;
      sb.id_wr = 1; sb.id_rd = 0; sb.wb_we = 1; sb.wb_a3 = 0;
      #1 chk("r0_stall", 32'(sb.id_stall), 32'd0);
      tick();
      idle();
      chk("r0_busy", sb.busy_mask, 32'h0);
      chk("r0_infl", 32'(sb.inflight), 32'd0);
      chk("r0_err", 32'(sb.err), 32'd0);

      // Same-register issue and retire, then error on idle register
      issue(5'd7);
      tick();
      sb.wb_we = 1; sb.wb_a3 = 5'd7;
      #1 chk("ir7_stall", 32'(sb.id_stall), 32'd0);
      tick();
      idle();
      chk("ir7_infl", 32'(sb.inflight), 32'd1);
      chk("ir7_busy", sb.busy_mask, 32'h0000_0080);
      chk("ir7_err", 32'(sb.err), 32'd0);
      sb.wb_we = 1; sb.wb_a3 = 5'd12;
      tick();
      idle();
      chk("err12", 32'(sb.err), 32'd1);
      chk("err12_infl", 32'(sb.inflight), 32'd1);
      sb.flush = 1;
      tick();
      idle();
      chk("err_fl", 32'(sb.err), 32'd1);
      chk("err_fl_infl", 32'(sb.inflight), 32'd0);

      // Asynchronous reset mid-operation
      issue(5'd3);
      tick();
      idle();
      chk("pre_rst_busy", sb.busy_mask, 32'h0000_0008);
      #2 rst = 1'b1;
      #1 chk("arst_busy", sb.busy_mask, 32'h0);
      chk("arst_infl", 32'(sb.inflight), 32'd0);
      chk("arst_err", 32'(sb.err), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_err", 32'(sb.err), 32'd0);

      // Bypass instance: last pending write retiring this cycle does not stall
      sb1.id_valid = 1; sb1.id_wr = 1; sb1.id_rd = 5'd5;
      tick();
      tick();
      idle1();
      chk("bp_infl", 32'(sb1.inflight), 32'd2);
      sb1.id_valid = 1; sb1.id_use_rs = 1; sb1.id_rs = 5'd5; sb1.wb_we = 1; sb1.wb_a3 = 5'd5;
      #1 chk("bp_cnt2", 32'(sb1.id_stall), 32'd1);
      tick();
      #1 chk("bp_cnt1", 32'(sb1.id_stall), 32'd0);
      sb1.wb_we = 0;
      #1 chk("bp_noret", 32'(sb1.id_stall), 32'd1);
      sb1.wb_we = 1;
      tick();
      idle1();
      chk("bp_done", 32'(sb1.inflight), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
